// File: rtl/noc_pkg.sv
// noc: shared NoC link types, credit sizing and flit preamble helper
package noc;

    localparam int PortQueueDepth = 4;
    localparam int CreditsWidth   = $clog2(PortQueueDepth + 1);
    localparam int MaxDataWidth   = 1024;

    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    typedef enum logic [0:0] {
        kTxIdle,
        kTxBody
    } noc_tx_state_t;

    // The preamble occupies the two MSBs of a flit of width data_width.
    function automatic preamble_t get_preamble(input logic [MaxDataWidth-1:0] flit, input int data_width);
        return preamble_t'(flit[data_width-1 -: 2]);
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// noc_credit_counter: saturating credit tracker with overflow pulse
module noc_credit_counter
    import noc::*;
#(
    parameter int Depth = PortQueueDepth,
    parameter int Width = CreditsWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             inc,
    output logic [Width-1:0] count,
    output logic             overflow
);

    logic full;

    assign full     = count == Width'(Depth);
    assign overflow = inc & ~dec & full;

    always_ff @(posedge clk) begin
        if (rst)
            count <= Width'(Depth);
        else if (dec & ~inc & (count != '0))
            count <= count - 1'b1;
        else if (inc & ~dec & ~full)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/noc_credit_tx_port.sv
// noc_credit_tx_port: credit-based NoC link transmitter with framing checks
module noc_credit_tx_port
    import noc::*;
#(
    parameter int DataWidth  = 64,
    parameter int QueueDepth = PortQueueDepth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DataWidth-1:0]    in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DataWidth-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    credit_in,
    output logic [CreditsWidth-1:0] credits,
    output logic                    in_packet,
    output logic                    framing_error,
    output logic                    credit_error
);

    noc_tx_state_t state, state_next;
    preamble_t     pre;
    logic          send, overflow, frame_bad;

    assign in_ready  = credits != '0;
    assign send      = in_valid & in_ready;
    assign in_packet = state == kTxBody;
    assign pre       = get_preamble(MaxDataWidth'(in_data), DataWidth);

    noc_credit_counter #(
        .Depth (QueueDepth),
        .Width (CreditsWidth)
    ) u_credits (
        .clk      (clk),
        .rst      (rst),
        .dec      (send),
        .inc      (credit_in),
        .count    (credits),
        .overflow (overflow)
    );

    // A head always starts a new packet, even when it interrupts one in flight.
    always_comb begin
        state_next = state;
        frame_bad  = 1'b0;
        if (send) begin
            state_next = pre.head ? (pre.tail ? kTxIdle : kTxBody)
                                  : ((state == kTxBody && !pre.tail) ? kTxBody : kTxIdle);
            frame_bad  = (state == kTxIdle) ? !pre.head : pre.head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            state         <= kTxIdle;
            framing_error <= 1'b0;
            credit_error  <= 1'b0;
        end else begin
            out_valid     <= send;
            if (send)
                out_data  <= in_data;
            state         <= state_next;
            framing_error <= framing_error | frame_bad;
            credit_error  <= credit_error | overflow;
        end
    end

endmodule
